// File: rtl/fir_out_quant.sv
// Output quantiser for the FIR engine: round-by-shift and saturate each
// accumulator result, buffer it in a small FIFO and re-emit it on AXI-Stream.
module fir_out_quant #(
   parameter int pDATA_WIDTH = 32,
   parameter int OUT_WIDTH   = 16,
   parameter int SHIFT       = 8,
   parameter int DEPTH       = 4
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   sm_tvalid,
   output logic [OUT_WIDTH-1:0]   sm_tdata,
   output logic                   sm_tlast,
   input  logic                   sm_tready,
   output logic [15:0]            sat_cnt,
   output logic [15:0]            frame_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = pDATA_WIDTH + 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic signed [TW-1:0] RND  = TW'((64'd1 << SHIFT) >> 1);
   localparam logic signed [TW-1:0] OMAX = TW'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
   localparam logic signed [TW-1:0] OMIN = ~OMAX;

   logic [OUT_WIDTH-1:0] mem_data [DEPTH];
   logic [DEPTH-1:0]     mem_last;
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic                 push;
   logic                 pop;

   logic signed [TW-1:0] t_val;
   logic signed [TW-1:0] r_val;
   logic                 sat_hi;
   logic                 sat_lo;
   logic [OUT_WIDTH-1:0] q_val;

   assign ss_tready = (count != FULL);
   assign sm_tvalid = (count != '0);
   assign push      = ss_tvalid & ss_tready;
   assign pop       = sm_tvalid & sm_tready;
   assign sm_tdata  = mem_data[rd_ptr];
   assign sm_tlast  = mem_last[rd_ptr];

   // One extra bit of headroom keeps the rounding add from overflowing.
   always_comb begin
      t_val  = $signed({ss_tdata[pDATA_WIDTH-1], ss_tdata}) + RND;
      r_val  = t_val >>> SHIFT;
      sat_hi = (r_val > OMAX);
      sat_lo = (r_val < OMIN);
      q_val  = r_val[OUT_WIDTH-1:0];
      if (sat_hi) begin
         q_val = OMAX[OUT_WIDTH-1:0];
      end else if (sat_lo) begin
         q_val = OMIN[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
         end
         mem_last <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= q_val;
            mem_last[wr_ptr] <= ss_tlast;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // sat_cnt sticks at all-ones; frame_cnt is allowed to wrap.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         sat_cnt   <= '0;
         frame_cnt <= '0;
      end else begin
         if (push && (sat_hi || sat_lo) && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
         end
         if (pop && sm_tlast) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fir_out_quant.sv
// Directed and randomised checks of fir_out_quant (32 -> 16 bit, shift 8, depth 4)
// against hand-computed values and a queue-based reference model.
module tb_fir_out_quant;

   logic        clk;
   logic        rst_n;
   logic        ss_tvalid;
   logic [31:0] ss_tdata;
   logic        ss_tlast;
   logic        ss_tready;
   logic        sm_tvalid;
   logic [15:0] sm_tdata;
   logic        sm_tlast;
   logic        sm_tready;
   logic [15:0] sat_cnt;
   logic [15:0] frame_cnt;

   typedef struct {
      logic [15:0] data;
      logic        last;
   } exp_t;

   exp_t        sb_q[$];
   int          checks    = 0;
   int          failures  = 0;
   int          n_pop     = 0;
   logic [15:0] exp_sat   = '0;
   logic [15:0] exp_frame = '0;

   fir_out_quant #(
      .pDATA_WIDTH(32),
      .OUT_WIDTH  (16),
      .SHIFT      (8),
      .DEPTH      (4)
   ) dut (
      .axis_clk  (clk),
      .axis_rst_n(rst_n),
      .ss_tvalid (ss_tvalid),
      .ss_tdata  (ss_tdata),
      .ss_tlast  (ss_tlast),
      .ss_tready (ss_tready),
      .sm_tvalid (sm_tvalid),
      .sm_tdata  (sm_tdata),
      .sm_tlast  (sm_tlast),
      .sm_tready (sm_tready),
      .sat_cnt   (sat_cnt),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: round half up by adding 128, floor-shift by 8, clamp to 16 bits.
   function automatic void quant(input logic [31:0] x, output logic [15:0] q, output bit sat);
      longint t;
      longint r;
      t   = longint'($signed(x)) + 64'sd128;
      r   = t >>> 8;
      sat = 1'b1;
      if (r > 64'sd32767) begin
         q = 16'h7FFF;
      end else if (r < -64'sd32768) begin
         q = 16'h8000;
      end else begin
         q   = r[15:0];
         sat = 1'b0;
      end
   endfunction

   // Scoreboard: handshakes are observed on the falling edge ahead of the
   // rising edge that completes them.
   initial begin
      exp_t        e;
      logic [15:0] qv;
      bit          sv;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb_q.delete();
            exp_sat   = '0;
            exp_frame = '0;
         end else begin
            if (sm_tvalid && sm_tready) begin
               n_pop++;
               check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  check("sb_data", 32'(sm_tdata), 32'(e.data));
                  check("sb_last", 32'(sm_tlast), 32'(e.last));
                  if (e.last) exp_frame = exp_frame + 16'd1;
               end
            end
            if (ss_tvalid && ss_tready) begin
               quant(ss_tdata, qv, sv);
               e.data = qv;
               e.last = ss_tlast;
               sb_q.push_back(e);
               if (sv && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input string tag, input logic [31:0] x, input logic [15:0] exp);
      ss_tvalid = 1'b1;
      ss_tdata  = x;
      ss_tlast  = 1'b0;
      step();
      ss_tvalid = 1'b0;
      check({tag, "_valid"}, 32'(sm_tvalid), 32'd1);
      check({tag, "_data"}, 32'(sm_tdata), 32'(exp));
      step();
      check({tag, "_drained"}, 32'(sm_tvalid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pops0;
      int   stalls;
      int   sent;
      int   cyc;
      bit   rdy;
      logic [31:0] cur;
      logic        cur_last;

      rst_n     = 1'b0;
      ss_tvalid = 1'b0;
      ss_tdata  = '0;
      ss_tlast  = 1'b0;
      sm_tready = 1'b0;
      repeat (3) step();
      check("rst_tvalid", 32'(sm_tvalid), 32'd0);
      check("rst_tdata", 32'(sm_tdata), 32'd0);
      check("rst_tlast", 32'(sm_tlast), 32'd0);
      check("rst_sat", 32'(sat_cnt), 32'd0);
      check("rst_frame", 32'(frame_cnt), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      check("rst_ready", 32'(ss_tready), 32'd1);

      // Rounding
      sm_tready = 1'b1;
      push_one("rnd_384", 32'd384, 16'd2);
      push_one("rnd_255", 32'd255, 16'd1);
      push_one("rnd_127", 32'd127, 16'd0);
      push_one("rnd_m384", -32'sd384, 16'hFFFF);
      push_one("rnd_m385", -32'sd385, 16'hFFFE);
      check("rnd_sat", 32'(sat_cnt), 32'd0);

      // Saturation
      push_one("sat_max", 32'h7FFF_FFFF, 16'h7FFF);
      push_one("sat_min", 32'h8000_0000, 16'h8000);
      push_one("sat_edge", 32'd8388480, 16'h7FFF);
      check("sat_cnt", 32'(sat_cnt), 32'd3);

      // Back-pressure
      sm_tready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         ss_tvalid = 1'b1;
         ss_tdata  = 32'(k * 256);
         step();
      end
      check("bp_ready_full", 32'(ss_tready), 32'd0);
      check("bp_head", 32'(sm_tdata), 32'd1);
      ss_tdata = 32'd1280;
      repeat (3) step();
      check("bp_ready_hold", 32'(ss_tready), 32'd0);
      check("bp_head_stable", 32'(sm_tdata), 32'd1);
      check("bp_valid_hold", 32'(sm_tvalid), 32'd1);
      pops0     = n_pop;
      sm_tready = 1'b1;
      step();
      check("bp_no_push_when_full", 32'(sm_tdata), 32'd2);
      step();
      ss_tvalid = 1'b0;
      for (int c = 0; c < 20 && (n_pop - pops0) < 5; c++) step();
      check("bp_out_count", 32'(n_pop - pops0), 32'd5);

      // Streaming 400 samples back to back
      pops0  = n_pop;
      stalls = 0;
      for (int i = 0; i < 400; i++) begin
         ss_tvalid = 1'b1;
         ss_tdata  = 32'(i * 100);
         ss_tlast  = (i == 399);
         if (!ss_tready) stalls++;
         step();
      end
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
      check("stream_stalls", 32'(stalls), 32'd0);
      check("stream_pops_inflight", 32'(n_pop - pops0), 32'd399);
      step();
      check("stream_pops_total", 32'(n_pop - pops0), 32'd400);
      check("stream_frame", 32'(frame_cnt), 32'd1);

      // Random valid/ready
      sent     = 0;
      cyc      = 0;
      cur      = 32'h1234_5678;
      cur_last = 1'b0;
      while (sent < 1000 && cyc < 20000) begin
         ss_tvalid = 1'($urandom_range(0, 1));
         ss_tdata  = cur;
         ss_tlast  = cur_last;
         sm_tready = 1'($urandom_range(0, 1));
         rdy       = ss_tready;
         step();
         cyc++;
         if (ss_tvalid && rdy) begin
            sent++;
            if ($urandom_range(0, 3) == 0) cur = $urandom();
            else cur = 32'(int'($urandom_range(0, 20000000)) - 10000000);
            cur_last = ($urandom_range(0, 15) == 0);
         end
      end
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
      sm_tready = 1'b1;
      for (int c = 0; c < 20 && sm_tvalid; c++) step();
      step();
      check("rand_sent", 32'(sent), 32'd1000);
      check("rand_drained", 32'(sb_q.size()), 32'd0);
      check("rand_valid_low", 32'(sm_tvalid), 32'd0);
      check("rand_sat", 32'(sat_cnt), 32'(exp_sat));
      check("rand_frame", 32'(frame_cnt), 32'(exp_frame));

      // Reset with three entries buffered
      sm_tready = 1'b0;
      ss_tvalid = 1'b1;
      ss_tdata  = 32'h7FFF_FFFF;
      ss_tlast  = 1'b1;
      step();
      ss_tdata = 32'h0000_1000;
      ss_tlast = 1'b0;
      step();
      ss_tdata = 32'h0000_2000;
      step();
      ss_tvalid = 1'b0;
      check("mid_head", 32'(sm_tdata), 32'h7FFF);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 32'(sm_tvalid), 32'd0);
      check("mid_rst_tdata", 32'(sm_tdata), 32'd0);
      check("mid_rst_tlast", 32'(sm_tlast), 32'd0);
      check("mid_rst_sat", 32'(sat_cnt), 32'd0);
      check("mid_rst_frame", 32'(frame_cnt), 32'd0);
      step();
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      check("mid_rel_ready", 32'(ss_tready), 32'd1);
      check("mid_rel_valid", 32'(sm_tvalid), 32'd0);
      sm_tready = 1'b1;
      push_one("mid_first", 32'h0000_0300, 16'd3);
      check("mid_frame", 32'(frame_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
